// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the 4-point FFT front end.
// Imported by fft_frame_bank and fft_input_framer.
package fft_pkg;

    localparam int NPT         = 4;
    localparam int LOG2_NPT    = 2;
    localparam int DFLT_DATA_W = 16;

    typedef struct packed {
        logic [DFLT_DATA_W-1:0] re;
        logic [DFLT_DATA_W-1:0] im;
    } cplx_t;

    // Bit-reversed slot index for a 4-point frame
    function automatic logic [LOG2_NPT-1:0] bitrev2(input logic [LOG2_NPT-1:0] i);
        return {i[0], i[1]};
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One 4-slot complex sample register bank with per-slot write enables.
// Cleared synchronously on reset.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int DATA_W = DFLT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NPT-1:0]    we,
    input  logic [DATA_W-1:0] wr_re,
    input  logic [DATA_W-1:0] wr_im,
    output logic [DATA_W-1:0] rd_re [NPT],
    output logic [DATA_W-1:0] rd_im [NPT]
);

    // Slot storage: clear on reset, otherwise load the enabled slot
    always_ff @(posedge clk) begin
        for (int i = 0; i < NPT; i++) begin
            if (reset) begin
                rd_re[i] <= '0;
                rd_im[i] <= '0;
            end else if (we[i]) begin
                rd_re[i] <= wr_re;
                rd_im[i] <= wr_im;
            end
        end
    end

endmodule

// File: rtl/fft_input_framer.sv
// Serial-to-frame ping-pong buffer feeding fft_4point.
// Define FFT_FRAMER_BITREV_EN for bit-reversed (DIT) slot order.
module fft_input_framer
    import fft_pkg::*;
#(
    parameter int DATA_W = DFLT_DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_re,
    input  logic [DATA_W-1:0] s_im,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] x0_re,
    output logic [DATA_W-1:0] x1_re,
    output logic [DATA_W-1:0] x2_re,
    output logic [DATA_W-1:0] x3_re,
    output logic [DATA_W-1:0] x0_im,
    output logic [DATA_W-1:0] x1_im,
    output logic [DATA_W-1:0] x2_im,
    output logic [DATA_W-1:0] x3_im,
    output logic [CNT_W-1:0]  frame_cnt
);

    logic                wr_bank;
    logic                rd_bank;
    logic [LOG2_NPT-1:0] wr_idx;
    logic [LOG2_NPT-1:0] slot;
    logic [1:0]          full;
    logic [1:0]          full_nxt;
    logic                accept;
    logic                handoff;
    logic                last;
    logic [NPT-1:0]      slot_oh;
    logic [NPT-1:0]      we0;
    logic [NPT-1:0]      we1;

    logic [DATA_W-1:0] b0_re [NPT];
    logic [DATA_W-1:0] b0_im [NPT];
    logic [DATA_W-1:0] b1_re [NPT];
    logic [DATA_W-1:0] b1_im [NPT];

    assign s_ready = !full[wr_bank];
    assign m_valid = full[rd_bank];
    assign accept  = s_valid && s_ready;
    assign handoff = m_valid && m_ready;
    assign last    = (wr_idx == LOG2_NPT'(NPT - 1));

`ifdef FFT_FRAMER_BITREV_EN
    assign slot = bitrev2(wr_idx);
`else
    assign slot = wr_idx;
`endif

    // One-hot slot write enable, steered to the filling bank
    always_comb begin
        slot_oh       = '0;
        slot_oh[slot] = accept;
    end

    assign we0 = wr_bank ? '0 : slot_oh;
    assign we1 = wr_bank ? slot_oh : '0;

    // Completing one bank and draining the other never collide
    always_comb begin
        full_nxt = full;
        if (handoff)
            full_nxt[rd_bank] = 1'b0;
        if (accept && last)
            full_nxt[wr_bank] = 1'b1;
    end

    // Bank pointers, fill index, full flags and handoff counter
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_idx    <= '0;
            full      <= '0;
            frame_cnt <= '0;
        end else begin
            full <= full_nxt;
            if (accept) begin
                wr_idx <= wr_idx + LOG2_NPT'(1);
                if (last)
                    wr_bank <= !wr_bank;
            end
            if (handoff) begin
                rd_bank   <= !rd_bank;
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    fft_frame_bank #(.DATA_W(DATA_W)) u_bank0 (
        .clk   (clk),
        .reset (reset),
        .we    (we0),
        .wr_re (s_re),
        .wr_im (s_im),
        .rd_re (b0_re),
        .rd_im (b0_im)
    );

    fft_frame_bank #(.DATA_W(DATA_W)) u_bank1 (
        .clk   (clk),
        .reset (reset),
        .we    (we1),
        .wr_re (s_re),
        .wr_im (s_im),
        .rd_re (b1_re),
        .rd_im (b1_im)
    );

    assign x0_re = rd_bank ? b1_re[0] : b0_re[0];
    assign x1_re = rd_bank ? b1_re[1] : b0_re[1];
    assign x2_re = rd_bank ? b1_re[2] : b0_re[2];
    assign x3_re = rd_bank ? b1_re[3] : b0_re[3];
    assign x0_im = rd_bank ? b1_im[0] : b0_im[0];
    assign x1_im = rd_bank ? b1_im[1] : b0_im[1];
    assign x2_im = rd_bank ? b1_im[2] : b0_im[2];
    assign x3_im = rd_bank ? b1_im[3] : b0_im[3];

endmodule
